// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings and the
// pattern state machine encoding.
package led_seq_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 3;

  // Mode select encodings as presented on the mode input.
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ROTATE = 2'b01;
  localparam logic [MODE_W-1:0] MODE_FILL   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_HOLD   = 2'b11;

  // Pattern generator states.
  typedef enum logic [STATE_W-1:0] {
    ST_BOUNCE_UP = 3'd0,
    ST_BOUNCE_DN = 3'd1,
    ST_ROTATE    = 3'd2,
    ST_FILL      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_HOLD      = 3'd5
  } state_e;

endpackage : led_seq_pkg

// File: rtl/led_sequencer.sv
// LED pattern sequencer. Advances a NUM_LEDS-wide pattern by one step on each
// unpaused tick from the display-rate timing stage (counter.enable -> tick).
// Modes: bounce scanner, rotate, fill/drain, hold.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   tick        one-cycle step enable
//   mode        requested mode, sampled only on a step
//   pause       while high, ticks are discarded
//   leds        current pattern (registered)
//   dir         1 = moving/growing toward MSB, 0 = toward LSB (registered)
//   cycle_done  one-cycle pulse on the step that completes a period (registered)
//
// NUM_LEDS legal range is 2..32.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [MODE_W-1:0]   mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                dir,
  output logic                cycle_done
);

  localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [NUM_LEDS-1:0] leds_d;
  logic                dir_d;
  logic                done_d;
  logic                step_c;

  // Candidate next patterns for each advance flavour.
  logic [NUM_LEDS-1:0] shl_c, shr_c, rol_c, fill_c;

  assign step_c = tick & ~pause;
  assign shl_c  = {leds[NUM_LEDS-2:0], 1'b0};
  assign shr_c  = {1'b0, leds[NUM_LEDS-1:1]};
  assign rol_c  = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
  assign fill_c = {leds[NUM_LEDS-2:0], 1'b1};

  // State, pattern, mode and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOUNCE_UP;
      mode_q     <= MODE_BOUNCE;
      leds       <= LED_ONE;
      dir        <= 1'b1;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      leds       <= leds_d;
      dir        <= dir_d;
      cycle_done <= done_d;
    end
  end

  // Next-state and next-output logic; nothing moves except on a step.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    leds_d  = leds;
    dir_d   = dir;
    done_d  = 1'b0;

    if (step_c) begin
      if (mode != mode_q) begin
        // A mode change consumes the step as a load rather than an advance.
        mode_d = mode;
        case (mode)
          MODE_BOUNCE: begin
            leds_d  = LED_ONE;
            dir_d   = 1'b1;
            state_d = ST_BOUNCE_UP;
          end
          MODE_ROTATE: begin
            leds_d  = LED_ONE;
            dir_d   = 1'b1;
            state_d = ST_ROTATE;
          end
          MODE_FILL: begin
            leds_d  = LED_ONE;
            dir_d   = 1'b1;
            state_d = ST_FILL;
          end
          default: begin
            // Hold freezes whatever pattern and direction are showing.
            state_d = ST_HOLD;
          end
        endcase
      end else begin
        case (state_q)
          ST_BOUNCE_UP: begin
            leds_d = shl_c;
            if (shl_c[NUM_LEDS-1]) begin
              state_d = ST_BOUNCE_DN;
              dir_d   = 1'b0;
            end
          end
          ST_BOUNCE_DN: begin
            leds_d = shr_c;
            if (shr_c[0]) begin
              state_d = ST_BOUNCE_UP;
              dir_d   = 1'b1;
              done_d  = 1'b1;
            end
          end
          ST_ROTATE: begin
            leds_d = rol_c;
            // Period completes when the MSB wraps back around to bit 0.
            done_d = leds[NUM_LEDS-1];
          end
          ST_FILL: begin
            leds_d = fill_c;
            if (&fill_c) begin
              state_d = ST_DRAIN;
              dir_d   = 1'b0;
            end
          end
          ST_DRAIN: begin
            leds_d = shr_c;
            if (shr_c == '0) begin
              state_d = ST_FILL;
              dir_d   = 1'b1;
              done_d  = 1'b1;
            end
          end
          ST_HOLD: begin
            leds_d = leds;
          end
          default: begin
            state_d = ST_BOUNCE_UP;
          end
        endcase
      end
    end
  end

endmodule : led_sequencer

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (NUM_LEDS = 8). Stimulus records carry
// the expected post-edge outputs; expectations are queued on drive and popped
// when the DUT output is sampled.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] leds;
  logic       dir;
  logic       cycle_done;

  typedef struct {
    string      name;
    logic       rst;
    logic       tick;
    logic       pause;
    logic [1:0] mode;
    logic [7:0] exp_leds;
    logic       exp_dir;
    logic       exp_done;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] leds;
    logic       dir;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  led_sequencer #(.NUM_LEDS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .mode       (mode),
    .pause      (pause),
    .leds       (leds),
    .dir        (dir),
    .cycle_done (cycle_done)
  );

  always #10 clk = ~clk;

  task automatic add(input string name, input logic r, input logic t, input logic p,
                     input logic [1:0] m, input logic [7:0] l, input logic d,
                     input logic dn);
    vec_t v;
    v.name = name; v.rst = r; v.tick = t; v.pause = p; v.mode = m;
    v.exp_leds = l; v.exp_dir = d; v.exp_done = dn;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; tick = v.tick; pause = v.pause; mode = v.mode;
    e.name = v.name; e.leds = v.exp_leds; e.dir = v.exp_dir; e.done = v.exp_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      checks += 2;
      if (leds !== e.leds) begin
        errors++;
        $display("FAIL %s leds: got %02h expected %02h", e.name, leds, e.leds);
      end
      if (dir !== e.dir) begin
        errors++;
        $display("FAIL %s dir: got %b expected %b", e.name, dir, e.dir);
      end
      if (cycle_done !== e.done) begin
        errors++;
        $display("FAIL %s cycle_done: got %b expected %b", e.name, cycle_done, e.done);
      end
    end
  endtask

  initial begin
    vec_t hv;
    logic [7:0] l;

    rst = 1'b1; tick = 1'b0; pause = 1'b0; mode = 2'b00;

    // ---- vector table ----
    add("reset0", 1, 0, 0, 2'b00, 8'h01, 1, 0);
    add("reset1", 1, 1, 1, 2'b10, 8'h01, 1, 0);
    for (int i = 0; i < 20; i++)  // mode wiggles without tick must not take effect
      add("idle", 0, 0, 0, (i < 10) ? 2'b00 : 2'b01, 8'h01, 1, 0);

    for (int i = 1; i <= 14; i++) begin
      l = (i <= 7) ? 8'(1 << i) : 8'(8'h80 >> (i - 7));
      add("bounce", 0, 1, 0, 2'b00, l, (i < 7) || (i == 14), i == 14);
    end
    add("bounce_idle", 0, 0, 0, 2'b00, 8'h01, 1, 0);

    add("rot_load", 0, 1, 0, 2'b01, 8'h01, 1, 0);
    for (int i = 1; i <= 8; i++)  // back-to-back ticks
      add("rotate", 0, 1, 0, 2'b01, 8'(1 << (i % 8)), 1, i == 8);
    add("rot_idle", 0, 0, 0, 2'b01, 8'h01, 1, 0);

    add("fill_load", 0, 1, 0, 2'b10, 8'h01, 1, 0);
    for (int i = 1; i <= 15; i++) begin
      l = (i <= 7) ? 8'((1 << (i + 1)) - 1) : 8'(8'hFF >> (i - 7));
      add("fill_drain", 0, 1, 0, 2'b10, l, (i < 7) || (i == 15), i == 15);
    end
    add("fill_wrap", 0, 1, 0, 2'b10, 8'h01, 1, 0);
    add("fill_step", 0, 1, 0, 2'b10, 8'h03, 1, 0);

    for (int i = 0; i < 5; i++)  // paused ticks, including a pending mode change
      add("pause", 0, 1, 1, (i % 2 == 1) ? 2'b01 : 2'b10, 8'h03, 1, 0);
    for (int i = 0; i < 5; i++)
      add("hold", 0, 1, 0, 2'b11, 8'h03, 1, 0);

    add("refill_load", 0, 1, 0, 2'b10, 8'h01, 1, 0);
    for (int i = 1; i <= 9; i++) begin  // ends in DRAIN at 0x3F
      l = (i <= 7) ? 8'((1 << (i + 1)) - 1) : 8'(8'hFF >> (i - 7));
      add("refill", 0, 1, 0, 2'b10, l, i < 7, 0);
    end

    foreach (vecs[k]) apply(vecs[k]);

    // ---- hand-written: reset wins over tick and mode change mid-drain ----
    hv.name = "rst_in_drain"; hv.rst = 1; hv.tick = 1; hv.pause = 0; hv.mode = 2'b01;
    hv.exp_leds = 8'h01; hv.exp_dir = 1; hv.exp_done = 0;
    apply(hv);
    // mode_q must be back at bounce: mode=00 advances rather than loads
    hv.name = "mode_q_reset"; hv.rst = 0; hv.tick = 1; hv.pause = 0; hv.mode = 2'b00;
    hv.exp_leds = 8'h02; hv.exp_dir = 1; hv.exp_done = 0;
    apply(hv);
    hv.name = "post_idle"; hv.tick = 0;
    apply(hv);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    checks++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_led_sequencer

// File: doc/led_sequencer.md
# led_sequencer

Pattern generator that consumes the periodic one-cycle enable pulse from the display-rate timing stage and advances an LED pattern by one step per pulse. It sits directly downstream of the ~175 ms tick generator and drives the board LEDs. Four selectable modes are supported: bounce scanner, rotate, fill/drain, and hold. Pause and cycle-complete signalling are included.

## Interface
- NUM_LEDS, default 8: pattern width; legal range 2..32.
- clk  input  1  50 MHz system clock.
- rst  input  1  Synchronous, active-high reset. Sampled on rising clk.
- tick  input  1  One-cycle step enable from the timing stage.
- mode  input  2  00 bounce, 01 rotate, 10 fill/drain, 11 hold. Sampled only on tick.
- pause  input  1  While 1, ticks are ignored entirely.
- leds  output  NUM_LEDS  Current pattern (registered).
- dir  output  1  1 = pattern moving/growing toward MSB, 0 = toward LSB (registered).
- cycle_done  output  1  One-cycle pulse when a pattern period completes (registered).

## Operation
- A step is the edge where tick=1 and pause=0. No other edge changes leds, dir, state, or mode_q.
- Internal register mode_q holds the active mode.
- Mode change: a step with mode≠mode_q performs a load, not an advance.
  - Modes 00/01/10: leds=0x…01, dir=1, state = BOUNCE_UP, ROTATE, or FILL respectively.
  - Mode 11: leds and dir are retained; state = HOLD.
  - mode_q←mode and cycle_done=0 in all cases.
- States and the advance on each step:
  - BOUNCE_UP: shift left. On reaching bit N-1 → BOUNCE_DN, dir=0.
  - BOUNCE_DN: shift right. On reaching bit 0 → BOUNCE_UP, dir=1, and cycle_done=1.
  - ROTATE: rotate left. The wrap from bit N-1 to bit 0 sets cycle_done=1.
  - FILL: leds←{leds[N-2:0],1}. On reaching all-ones → DRAIN, dir=0.
  - DRAIN: leds←{0,leds[N-1:1]}. On reaching all-zeros → FILL, dir=1, and cycle_done=1. The next step yields 0x…01.
  - HOLD: no change.
- cycle_done is 0 on every cycle other than the completing step's output cycle.
- Periods: bounce 2N-2 steps, rotate N steps, fill/drain 2N steps.

## Timing
- Reset values: leds=0x…01, dir=1, cycle_done=0, state=BOUNCE_UP, mode_q=00.
- Latency: outputs reflect a step one cycle after the tick edge, i.e. registered on the same edge that samples tick.
- rst=1 overrides a simultaneous tick, pause, or mode change.
- Reset mid-pattern returns to the reset values on the next edge, regardless of state.
- Back-to-back ticks on consecutive cycles must each produce one step. There is no minimum tick spacing.
- pause=1 coincident with tick discards that tick. It is not deferred.
- A mode change that occurs without a tick takes no effect until the next step.

## Structure
- Shared package led_seq_pkg holds:
  - mode encodings MODE_BOUNCE, MODE_ROTATE, MODE_FILL, MODE_HOLD;
  - state enum with members ST_BOUNCE_UP, ST_BOUNCE_DN, ST_ROTATE, ST_FILL, ST_DRAIN, ST_HOLD.
- No sub-module: the state register, pattern register, and mode_q live in one module.
- The top level wires counter.enable → tick.

## Test plan
- Reset, then 20 idle cycles without tick → leds=0x01, dir=1, cycle_done=0 throughout.
- mode=00 (N=8), 14 steps → leds 0x02,0x04,…,0x80,0x40,…,0x01.
  - dir falls after step 7.
  - cycle_done=1 only after step 14.
- mode=01, first step loads 0x01. Next 8 steps → 0x02…0x80,0x01, with cycle_done only on the 0x01 step.
- mode=10, first step loads 0x01. Next 15 steps → 0x03,0x07,…,0xFF,0x7F,…,0x00.
  - cycle_done is asserted at 0x00.
  - The following step gives 0x01 with dir=1.
- pause=1 with 5 ticks → no change. mode=11 with 5 ticks → leds frozen at the current value.
  - Back-to-back ticks in mode 01 → one rotation step per cycle.
- In DRAIN at 0x3F, assert rst together with tick → next cycle leds=0x01, dir=1, cycle_done=0, mode_q=00.
